// File: rtl/fila_consumer.sv
// fila_consumer: drain stage for the 8x8 FILA queue (pop, capture, valid/ready out).
// Optional FILA_CONSUMER_CHECKSUM_EN adds checksum_out (rotl1 of running XOR).
module fila_consumer #(
  parameter int unsigned DEQ_LAT = 3,
  parameter int unsigned GAP     = 1
) (
  input  logic       clock_10KHz,
  input  logic       reset,
  input  logic [3:0] len_in,
  input  logic [7:0] data_in,
  input  logic       ready_in,
  output logic       dequeue_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [7:0] count_out,
  output logic       busy_out,
  output logic       err_out
`ifdef FILA_CONSUMER_CHECKSUM_EN
  ,
  output logic [7:0] checksum_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_COOL
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(DEQ_LAT - 1);
  localparam logic [2:0] GAP_INIT = 3'(GAP);

  state_t     state_q;
  logic [2:0] lat_cnt_q;
  logic [2:0] gap_cnt_q;
  logic [3:0] len_snap_q;
  logic       deq_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic [7:0] count_q;
  logic       busy_q;
  logic       err_q;

`ifdef FILA_CONSUMER_CHECKSUM_EN
  logic [7:0] ck_q;
  logic [7:0] ck_mix;

  assign ck_mix = ck_q ^ data_q;

  // Fold each delivered byte into the running checksum.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      ck_q <= 8'd0;
    end else if (state_q == S_HOLD && ready_in) begin
      ck_q <= {ck_mix[6:0], ck_mix[7]};
    end
  end

  assign checksum_out = ck_q;
`endif

  // Pop / capture / handshake / cool-down sequencing with registered outputs.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= 3'd0;
      gap_cnt_q  <= 3'd0;
      len_snap_q <= 4'd0;
      deq_q      <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      count_q    <= 8'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (len_in != 4'd0) begin
            deq_q      <= 1'b1;
            lat_cnt_q  <= LAT_INIT;
            len_snap_q <= len_in;
            state_q    <= S_WAIT;
            busy_q     <= 1'b1;
          end
        end
        S_WAIT: begin
          deq_q <= 1'b0;
          if (lat_cnt_q != 3'd0) begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end else begin
            data_q  <= data_in;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
            if (len_in != len_snap_q - 4'd1) begin
              err_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (ready_in) begin
            valid_q   <= 1'b0;
            count_q   <= count_q + 8'd1;
            gap_cnt_q <= GAP_INIT;
            if (GAP == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_COOL;
            end
          end
        end
        S_COOL: begin
          gap_cnt_q <= gap_cnt_q - 3'd1;
          if (gap_cnt_q == 3'd1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dequeue_out = deq_q;
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign count_out   = count_q;
  assign busy_out    = busy_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_fila_consumer.sv
// tb_fila_consumer: directed + random drive of fila_consumer against
// a timestamp-based reference model and a queue environment.
module tb_fila_consumer;

  localparam int DEQ_LAT = 3;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] len_in = 4'd0;
  logic [7:0] data_in = 8'd0;
  logic       ready_in = 1'b0;
  logic       dequeue_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic [7:0] count_out;
  logic       busy_out;
  logic       err_out;
`ifdef FILA_CONSUMER_CHECKSUM_EN
  logic [7:0] checksum_out;
`endif

  fila_consumer #(.DEQ_LAT(DEQ_LAT), .GAP(GAP)) dut (
    .clock_10KHz (clk),
    .reset       (rst_n),
    .len_in      (len_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .dequeue_out (dequeue_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .count_out   (count_out),
    .busy_out    (busy_out),
    .err_out     (err_out)
`ifdef FILA_CONSUMER_CHECKSUM_EN
    ,
    .checksum_out(checksum_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int npulse = 0;
  bit stuck = 1'b0;
  logic [7:0] q[$];

  // reference model: transaction timestamps, not a state machine copy
  bit         m_busy, m_valid, m_cool, m_err, m_deq;
  int         m_pop_at, m_idle_at;
  int         m_snap;
  logic [7:0] m_data, m_count, m_ck;

  function automatic logic [7:0] rotl1(logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_valid = 0; m_cool = 0; m_err = 0; m_deq = 0;
    m_pop_at = -100; m_idle_at = 0; m_snap = 0;
    m_data = 8'd0; m_count = 8'd0; m_ck = 8'd0;
  endfunction

  task automatic model_edge();
    m_deq = 0;
    if (!m_busy) begin
      if (len_in != 4'd0) begin
        m_busy = 1; m_pop_at = cyc; m_snap = int'(len_in); m_deq = 1;
      end
    end else if (m_cool) begin
      if (cyc >= m_idle_at) begin
        m_busy = 0; m_cool = 0;
      end
    end else if (m_valid) begin
      if (ready_in) begin
        m_valid = 0;
        m_count = m_count + 8'd1;
        m_ck = rotl1(m_ck ^ m_data);
        if (GAP == 0) m_busy = 0;
        else begin m_cool = 1; m_idle_at = cyc + GAP; end
      end
    end else if (cyc == m_pop_at + DEQ_LAT) begin
      m_data = data_in; m_valid = 1;
      if (int'(len_in) != m_snap - 1) m_err = 1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dequeue_out", 32'(dequeue_out), 32'(m_deq));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("count_out", 32'(count_out), 32'(m_count));
    chk("busy_out", 32'(busy_out), 32'(m_busy));
    chk("err_out", 32'(err_out), 32'(m_err));
`ifdef FILA_CONSUMER_CHECKSUM_EN
    chk("checksum_out", 32'(checksum_out), 32'(m_ck));
`endif
  endtask

  // queue environment reacts to pops just after the edge
  task automatic env_react();
    if (dequeue_out) begin
      npulse++;
      if (stuck) begin
        data_in = 8'($urandom);
      end else if (q.size() > 0) begin
        data_in = q.pop_front();
        len_in = 4'(q.size());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
    env_react();
  endtask

  initial begin
    model_reset();
    q = '{8'hA5, 8'h11, 8'h22};
    len_in = 4'd3;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // first pop, capture at E0+3, hold for 10 cycles
    step();
    chk("pulse_E0", 32'(dequeue_out), 32'd1);
    chk("busy_E0", 32'(busy_out), 32'd1);
    repeat (3) step();
    chk("cap_data", 32'(data_out), 32'hA5);
    chk("cap_valid", 32'(valid_out), 32'd1);
    repeat (10) step();
    chk("hold_data", 32'(data_out), 32'hA5);
    chk("hold_valid", 32'(valid_out), 32'd1);
    chk("hold_count", 32'(count_out), 32'd0);
    ready_in = 1'b1;
    step();
    chk("hs_valid", 32'(valid_out), 32'd0);
    chk("hs_count", 32'(count_out), 32'd1);
    repeat (20) step();
    chk("pulses3", 32'(npulse), 32'd3);
    chk("count3", 32'(count_out), 32'd3);
    chk("idle3", 32'(busy_out), 32'd0);
    chk("noerr3", 32'(err_out), 32'd0);

    // queue length that never shrinks
    stuck = 1'b1;
    len_in = 4'd2;
    repeat (4) step();
    chk("err_set", 32'(err_out), 32'd1);
    chk("err_valid", 32'(valid_out), 32'd1);
    repeat (15) step();
    chk("err_sticky", 32'(err_out), 32'd1);
    stuck = 1'b0;
    len_in = 4'd0;
    repeat (10) step();
    chk("err_idle", 32'(busy_out), 32'd0);

    // asynchronous reset in the middle of WAIT
    q = '{8'h5A};
    len_in = 4'd1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_deq", 32'(dequeue_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    q = '{8'hC3};
    len_in = 4'd1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_pulse", 32'(dequeue_out), 32'd1);
    repeat (10) step();
    chk("rst_data", 32'(data_out), 32'hC3);
    chk("rst_count1", 32'(count_out), 32'd1);

    // random enqueues and ready back-pressure
    for (int i = 0; i < 600; i++) begin
      ready_in = ($urandom_range(0, 9) < 7);
      if (q.size() < 8 && $urandom_range(0, 3) == 0) begin
        q.push_back(8'($urandom));
        len_in = 4'(q.size());
      end
      step();
    end
    ready_in = 1'b1;
    repeat (80) step();
    chk("final_idle", 32'(busy_out), 32'd0);
    chk("final_count", 32'(count_out), 32'(m_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
